regfile_writeback_buffer: RTL
=============================

Name: regfile_writeback_buffer

Overview:
- Write-side companion to the register file. Queues writeback requests from pipeline producers (ALU, load, multi-cycle units) in a small FIFO.
- Drains the FIFO one entry per cycle into the register file write port (reg_write_en / reg_write_dest / reg_write_data).
- Provides two bypass lookup ports so decode can read values that are queued but not yet written.

Parameters:
- DEPTH, 4, FIFO entries (power of two, at least 2).
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (low = reset).
- wb_valid  in  1  producer has a writeback request.
- wb_ready  out  1  buffer can accept a request.
- wb_dest  in  ADDR_W  destination register.
- wb_data  in  DATA_W  writeback value.
- drain_en  in  1  register file write port available this cycle.
- reg_write_en  out  1  write strobe to the register file.
- reg_write_dest  out  ADDR_W  register file write address.
- reg_write_data  out  DATA_W  register file write data.
- lookup_addr_1, lookup_addr_2  in  ADDR_W  decode read addresses.
- lookup_hit_1, lookup_hit_2  out  1  a pending write exists for that address.
- lookup_data_1, lookup_data_2  out  DATA_W  youngest pending value; 0 when no hit.
- count  out  clog2(DEPTH)+1  number of occupied FIFO entries.
- empty, full  out  1  count==0 / count==DEPTH.

Behaviour:
- Reset (reset low at posedge): wr_ptr, rd_ptr and count go to 0. reg_write_en, reg_write_dest and reg_write_data go to 0. Stored entries are discarded. wb_valid and drain_en are ignored during reset cycles. After reset: empty=1, full=0, wb_ready=1, both lookup_hit outputs 0.
- wb_ready = !full. It is a function of registered state only, with no combinational path from drain_en.
- Accept: wb_valid && wb_ready at a posedge completes the handshake.
  - wb_dest != 0: the entry is written at wr_ptr, wr_ptr wraps modulo DEPTH, count increments.
  - wb_dest == 0: the handshake completes but nothing is stored; count is unchanged.
- Pop: drain_en && !empty at a posedge.
  - The head entry loads into the registered output stage: reg_write_en=1, dest and data from the head.
  - rd_ptr wraps modulo DEPTH, count decrements.
  - Otherwise reg_write_en=0 on the next cycle; dest and data hold their last values.
- Push and pop in the same cycle: count is unchanged. When full, the pop frees no slot for that same edge because wb_ready was already 0.
- Latency: a request accepted at edge N into an empty buffer with drain_en held high is presented on reg_write_* during the cycle after edge N+1. The register file commits it at edge N+2. Throughput is 1 write per cycle.
- The register file writes at posedge when reg_write_en=1. Register 0 is never written because dest 0 is never queued.
- Lookup (combinational):
  - Searches valid FIFO entries and the output stage (while reg_write_en=1) for a dest match.
  - Priority: youngest FIFO entry, then older entries, then the output stage.
  - Address 0 never hits.
  - The same-cycle incoming wb_* is not searched.
- Ordering: writes reach the register file strictly in acceptance order. Multiple queued writes to the same register are all issued; the last one wins.
- Reset asserted mid-drain: takes effect at that edge. Pending writes are lost and reg_write_en=0 on the next cycle.

Test Plan:
- Reset with buffer holding 3 entries and drain_en=0 -> next cycle count=0, empty=1, reg_write_en=0, lookup_hit_1=0 for those dests.
- Push {r5=0x11} with drain_en=1 -> count=1 after push edge. reg_write_en=1 with dest=5, data=0x11 one cycle later. lookup_hit_1=1 (addr 5) until reg_write_en drops.
- drain_en=0; push r1..r4 -> full=1, wb_ready=0. A 5th push (r6) is held off. Raise drain_en -> writes r1,r2,r3,r4,r6 appear in order on consecutive cycles.
- Push r7=0xA then r7=0xB, drain_en=0 -> lookup_addr_2=7 gives hit=1, data=0xB. Drain one entry -> data still 0xB.
- Push to r0 with wb_valid=1 -> wb_ready=1, count unchanged, no reg_write_en. lookup_addr_1=0 gives hit=0.
- Full buffer, push and pop asserted together, sustained for 10 cycles -> pushes stall until full drops. Afterwards count is never above DEPTH, writes appear in FIFO order, nothing is lost or duplicated.

Source files
------------

// File: rtl/regfile_writeback_buffer.sv
// regfile_writeback_buffer
// Write-side companion to the register file. Producers hand writeback requests
// to a small FIFO. The FIFO drains one entry per cycle into a registered
// register-file write port. Two combinational bypass ports let decode see values
// that are queued or in flight but not yet committed to the register file.

module regfile_writeback_buffer #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,

   input  logic                     wb_valid,
   output logic                     wb_ready,
   input  logic [ADDR_W-1:0]        wb_dest,
   input  logic [DATA_W-1:0]        wb_data,

   input  logic                     drain_en,
   output logic                     reg_write_en,
   output logic [ADDR_W-1:0]        reg_write_dest,
   output logic [DATA_W-1:0]        reg_write_data,

   input  logic [ADDR_W-1:0]        lookup_addr_1,
   input  logic [ADDR_W-1:0]        lookup_addr_2,
   output logic                     lookup_hit_1,
   output logic                     lookup_hit_2,
   output logic [DATA_W-1:0]        lookup_data_1,
   output logic [DATA_W-1:0]        lookup_data_2,

   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_REG   = '0;

   // FIFO storage; an entry is meaningful only while its age is below occupancy
   logic [ADDR_W-1:0] entry_dest [DEPTH];
   logic [DATA_W-1:0] entry_data [DEPTH];

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  occupancy;

   logic              accept;
   logic              store;
   logic              pop;

   // Status flags come only from registered occupancy, so wb_ready never
   // depends combinationally on drain_en.
   assign full     = (occupancy == FULL_COUNT);
   assign empty    = (occupancy == '0);
   assign wb_ready = !full;
   assign count    = occupancy;

   // A handshake to register 0 completes but stores nothing, since r0 is never written.
   assign accept = wb_valid && wb_ready;
   assign store  = accept && (wb_dest != ZERO_REG);
   assign pop    = drain_en && !empty;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (store) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({store, pop})
            2'b10:   occupancy <= occupancy + CNT_W'(1);
            2'b01:   occupancy <= occupancy - CNT_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Entry payload write; storage is not cleared because occupancy defines validity.
   always_ff @(posedge clk) begin
      if (reset && store) begin
         entry_dest[wr_ptr] <= wb_dest;
         entry_data[wr_ptr] <= wb_data;
      end
   end

   // Registered register-file write stage; dest/data hold when no entry is popped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         reg_write_en   <= 1'b0;
         reg_write_dest <= '0;
         reg_write_data <= '0;
      end else if (pop) begin
         reg_write_en   <= 1'b1;
         reg_write_dest <= entry_dest[rd_ptr];
         reg_write_data <= entry_data[rd_ptr];
      end else begin
         reg_write_en   <= 1'b0;
      end
   end

   // Bypass search: the output stage is the oldest candidate, then FIFO entries
   // from oldest to youngest, so the youngest match overrides everything older.
   function automatic void search_pending(
      input  logic [ADDR_W-1:0] addr,
      output logic              hit,
      output logic [DATA_W-1:0] data
   );
      logic [PTR_W-1:0] slot;
      hit  = 1'b0;
      data = '0;
      slot = '0;
      if (addr != ZERO_REG) begin
         if (reg_write_en && (reg_write_dest == addr)) begin
            hit  = 1'b1;
            data = reg_write_data;
         end
         for (int age = 0; age < DEPTH; age++) begin
            slot = rd_ptr + PTR_W'(age);
            if ((CNT_W'(age) < occupancy) && (entry_dest[slot] == addr)) begin
               hit  = 1'b1;
               data = entry_data[slot];
            end
         end
      end
   endfunction

   // First decode bypass port.
   always_comb begin
      lookup_hit_1  = 1'b0;
      lookup_data_1 = '0;
      search_pending(lookup_addr_1, lookup_hit_1, lookup_data_1);
   end

   // Second decode bypass port.
   always_comb begin
      lookup_hit_2  = 1'b0;
      lookup_data_2 = '0;
      search_pending(lookup_addr_2, lookup_hit_2, lookup_data_2);
   end

endmodule
